// File: rtl/pulse_stretcher_pkg.sv
// Shared encodings for the pulse stretcher: FSM states and trigger modes.
// Mode 3 is reserved and is decoded as one-shot by the stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RETRIG  = 2'd1;
    localparam logic [1:0] MODE_TOGGLE  = 2'd2;

endpackage

// File: rtl/pulse_stretcher.sv
// Turns one-cycle trigger pulses into levels: a programmable-length stretch
// (one-shot or retriggerable) or a toggled hold level.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [1:0]       mode_i,
    output logic             out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] lenClamped;

    // A zero length still produces a one-cycle stretch.
    assign lenClamped = (len_i == '0) ? CNT_W'(1) : len_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_ONESHOT;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            out_q     <= out_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_i) begin
                    mode_d = mode_i;
                    if (mode_i == MODE_TOGGLE) begin
                        state_d = HOLD;
                    end else begin
                        state_d = STRETCH;
                        cnt_d   = lenClamped;
                    end
                end
            end
            STRETCH: begin
                // A retrigger wins even on the last counted cycle; the counter parks at 1.
                if (in_i && (mode_q == MODE_RETRIG)) begin
                    cnt_d = lenClamped;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (in_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_d     = (state_d != IDLE);
        done_d    = (state_q != IDLE) && (state_d == IDLE);
        overrun_d = (state_q == STRETCH) && in_i && (mode_q != MODE_RETRIG);
    end

    assign out_o     = out_q;
    assign busy_o    = out_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a vector table of per-cycle inputs and
// the outputs expected in the following cycle, plus hand-written sequences.
module tb_pulse_stretcher;

    typedef struct {
        logic       inV;
        logic [7:0] lenV;
        logic [1:0] modeV;
        logic       expOut;
        logic       expDone;
        logic       expOvr;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       inSig;
    logic [7:0] lenSig;
    logic [1:0] modeSig;
    logic       outSig;
    logic       busySig;
    logic       doneSig;
    logic       overrunSig;

    int   vectorCount;
    int   missCount;
    vec_t vecs[$];

    pulse_stretcher #(.CNT_W(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .in_i      (inSig),
        .len_i     (lenSig),
        .mode_i    (modeSig),
        .out_o     (outSig),
        .busy_o    (busySig),
        .done_o    (doneSig),
        .overrun_o (overrunSig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation still running, expected to finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic inV, input logic [7:0] lenV, input logic [1:0] modeV);
        @(negedge clk);
        inSig   = inV;
        lenSig  = lenV;
        modeSig = modeV;
    endtask

    task automatic checkNow(input string name, input logic eOut, input logic eDone, input logic eOvr);
        vectorCount++;
        if (outSig !== eOut || busySig !== eOut || doneSig !== eDone || overrunSig !== eOvr) begin
            missCount++;
            $display("[TB] FAIL %s: got out=%b busy=%b done=%b overrun=%b, expected out=%b busy=%b done=%b overrun=%b",
                     name, outSig, busySig, doneSig, overrunSig, eOut, eOut, eDone, eOvr);
        end
    endtask

    task automatic checkOutput(input string name, input logic eOut, input logic eDone, input logic eOvr);
        @(posedge clk);
        #1;
        checkNow(name, eOut, eDone, eOvr);
    endtask

    task automatic addVec(input logic i, input logic [7:0] l, input logic [1:0] m,
                          input logic o, input logic d, input logic v);
        vec_t t;
        t.inV = i; t.lenV = l; t.modeV = m;
        t.expOut = o; t.expDone = d; t.expOvr = v;
        vecs.push_back(t);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;

        // One-shot len 5, ignored trigger on the third high cycle.
        addVec(1, 5, 0, 1, 0, 0);
        addVec(0, 5, 0, 1, 0, 0);
        addVec(0, 5, 0, 1, 0, 0);
        addVec(1, 9, 1, 1, 0, 1);
        addVec(0, 9, 1, 1, 0, 0);
        addVec(0, 5, 0, 0, 1, 0);
        addVec(0, 5, 0, 0, 0, 0);
        // len 0 behaves as 1.
        addVec(1, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0);
        // Retriggerable len 4, pulses at T and T+3.
        addVec(1, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(1, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 0, 1, 0);
        addVec(0, 4, 1, 0, 0, 0);
        // Retrigger on the final cycle reloads with the current len (2).
        addVec(1, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(0, 4, 1, 1, 0, 0);
        addVec(1, 2, 1, 1, 0, 0);
        addVec(0, 2, 1, 1, 0, 0);
        addVec(0, 2, 1, 0, 1, 0);
        addVec(0, 2, 1, 0, 0, 0);
        // Back-to-back one-shot len 2, second trigger in the done cycle.
        addVec(1, 2, 0, 1, 0, 0);
        addVec(0, 2, 0, 1, 0, 0);
        addVec(0, 2, 0, 0, 1, 0);
        addVec(1, 2, 0, 1, 0, 0);
        addVec(0, 2, 0, 1, 0, 0);
        addVec(0, 2, 0, 0, 1, 0);
        addVec(0, 2, 0, 0, 0, 0);
        // Trigger on the cnt==1 cycle: overrun, no restart.
        addVec(1, 2, 0, 1, 0, 0);
        addVec(0, 2, 0, 1, 0, 0);
        addVec(1, 2, 0, 0, 1, 1);
        addVec(0, 2, 0, 0, 0, 0);
        // Reserved mode 3 acts as one-shot.
        addVec(1, 3, 3, 1, 0, 0);
        addVec(1, 3, 3, 1, 0, 1);
        addVec(0, 3, 3, 1, 0, 0);
        addVec(0, 3, 3, 0, 1, 0);
        addVec(0, 3, 3, 0, 0, 0);
        // Toggle with in held high.
        addVec(1, 5, 2, 1, 0, 0);
        addVec(1, 5, 2, 0, 1, 0);
        addVec(1, 5, 2, 1, 0, 0);
        addVec(1, 5, 2, 0, 1, 0);
        addVec(0, 5, 2, 0, 0, 0);
        // Retriggerable with in held high, then len more cycles.
        addVec(1, 2, 1, 1, 0, 0);
        addVec(1, 2, 1, 1, 0, 0);
        addVec(1, 2, 1, 1, 0, 0);
        addVec(0, 2, 1, 1, 0, 0);
        addVec(0, 2, 1, 0, 1, 0);
        addVec(0, 2, 1, 0, 0, 0);

        rst_n   = 1'b0;
        inSig   = 1'b0;
        lenSig  = 8'd0;
        modeSig = 2'd0;
        #3;
        checkNow("reset_state", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_release", 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].inV, vecs[i].lenV, vecs[i].modeV);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].expOut, vecs[i].expDone, vecs[i].expOvr);
        end

        // Toggle hold for 20 cycles while len/mode wander.
        applyStimulus(1, 5, 2);
        checkOutput("hold_start", 1, 0, 0);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(0, 8'(k * 7), 2'(k));
            checkOutput($sformatf("hold_cycle%0d", k), 1, 0, 0);
        end
        applyStimulus(1, 1, 0);
        checkOutput("hold_end", 0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("hold_after", 0, 0, 0);

        // Asynchronous reset in the middle of a len 10 stretch.
        applyStimulus(1, 10, 0);
        checkOutput("rst_stretch1", 1, 0, 0);
        applyStimulus(0, 10, 0);
        checkOutput("rst_stretch2", 1, 0, 0);
        applyStimulus(0, 10, 0);
        checkOutput("rst_stretch3", 1, 0, 0);
        applyStimulus(0, 10, 0);
        checkOutput("rst_stretch4", 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkNow("rst_async", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_no_done", 0, 0, 0);
        applyStimulus(0, 3, 0);
        checkOutput("rst_idle", 0, 0, 0);
        applyStimulus(1, 3, 0);
        checkOutput("post_rst1", 1, 0, 0);
        applyStimulus(0, 3, 0);
        checkOutput("post_rst2", 1, 0, 0);
        applyStimulus(0, 3, 0);
        checkOutput("post_rst3", 1, 0, 0);
        applyStimulus(0, 3, 0);
        checkOutput("post_rst_done", 0, 1, 0);
        applyStimulus(0, 3, 0);
        checkOutput("post_rst_idle", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
